// File: rtl/dma_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_ctrl_if
// Brief    : Single-outstanding ICB master bundle (command + response
//            channels) used between the DMA sequencer and the bus.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_xfer_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            m_cmd_valid;
  logic            m_cmd_ready;
  logic [AW-1:0]   m_cmd_addr;
  logic            m_cmd_read;
  logic [DW-1:0]   m_cmd_wdata;
  logic [DW/8-1:0] m_cmd_wmask;
  logic            m_rsp_valid;
  logic            m_rsp_ready;
  logic            m_rsp_err;
  logic [DW-1:0]   m_rsp_rdata;

  modport master (
    output m_cmd_valid, m_cmd_addr, m_cmd_read, m_cmd_wdata, m_cmd_wmask, m_rsp_ready,
    input  m_cmd_ready, m_rsp_valid, m_rsp_err, m_rsp_rdata
  );

  modport slave (
    input  m_cmd_valid, m_cmd_addr, m_cmd_read, m_cmd_wdata, m_cmd_wmask, m_rsp_ready,
    output m_cmd_ready, m_rsp_valid, m_rsp_err, m_rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_xfer_ctrl
// Brief    : DMA sequencer. Latches a line x row configuration on cfg_vld and
//            copies contiguous 32-bit words one at a time (read, then write)
//            over a single-outstanding ICB master. Reports busy/done/err.
// Revision : 1.0 - initial release
// ============================================================================
module dma_xfer_ctrl #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int STEP = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        cfg_vld,
  input  wire logic [31:0] sour_addr,
  input  wire logic [31:0] dest_addr,
  input  wire logic [31:0] line_size,
  input  wire logic [31:0] row_size,
  output logic      [2:0]  dma_ctr,
  output logic             done_pulse,
  dma_xfer_ctrl_if.master  m
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_CMD = 3'd1;
  localparam logic [2:0] S_RD_RSP = 3'd2;
  localparam logic [2:0] S_WR_CMD = 3'd3;
  localparam logic [2:0] S_WR_RSP = 3'd4;

  localparam logic [AW-1:0] c_step_inc = AW'(STEP);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [31:0]   col_q, col_d;
  logic [31:0]   row_q, row_d;
  logic [31:0]   line_q, line_d;
  logic [31:0]   rows_q, rows_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          done_pulse_q, done_pulse_d;

  logic          cfg_ok;
  logic          end_of_line;
  logic          last_word;

  // A start with either dimension zero completes immediately without traffic
  assign cfg_ok      = (line_size != 32'd0) && (row_size != 32'd0);
  assign end_of_line = (col_q == line_q - 32'd1);
  assign last_word   = end_of_line && (row_q == rows_q - 32'd1);

  // State register; async reset drops any transfer and in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one read then one write per word, abort on any error response
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_vld && cfg_ok)  state_d = S_RD_CMD;
      S_RD_CMD: if (m.m_cmd_ready)      state_d = S_RD_RSP;
      S_RD_RSP: if (m.m_rsp_valid)      state_d = m.m_rsp_err ? S_IDLE : S_WR_CMD;
      S_WR_CMD: if (m.m_cmd_ready)      state_d = S_WR_RSP;
      S_WR_RSP: if (m.m_rsp_valid)      state_d = (m.m_rsp_err || last_word) ? S_IDLE : S_RD_CMD;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from state; payload comes from registers so it is stable under backpressure
  always_comb begin
    m.m_cmd_valid = (state_q == S_RD_CMD) || (state_q == S_WR_CMD);
    m.m_cmd_read  = (state_q == S_RD_CMD);
    m.m_cmd_addr  = '0;
    m.m_cmd_wdata = '0;
    m.m_cmd_wmask = '0;
    m.m_rsp_ready = (state_q == S_RD_RSP) || (state_q == S_WR_RSP);
    if (state_q == S_RD_CMD) begin
      m.m_cmd_addr = src_ptr_q;
    end else if (state_q == S_WR_CMD) begin
      m.m_cmd_addr  = dst_ptr_q;
      m.m_cmd_wdata = buf_q;
      m.m_cmd_wmask = '1;
    end
  end

  // Datapath: config latch, pointers, line/row counters, data buffer and status
  always_comb begin
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    col_d        = col_q;
    row_d        = row_q;
    line_d       = line_q;
    rows_d       = rows_q;
    buf_d        = buf_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    done_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_vld) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (cfg_ok) begin
            src_ptr_d = AW'(sour_addr);
            dst_ptr_d = AW'(dest_addr);
            line_d    = line_size;
            rows_d    = row_size;
            col_d     = 32'd0;
            row_d     = 32'd0;
            busy_d    = 1'b1;
          end else begin
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
      end
      S_RD_RSP: begin
        if (m.m_rsp_valid) begin
          buf_d = m.m_rsp_rdata;
          if (m.m_rsp_err) begin
            busy_d       = 1'b0;
            err_d        = 1'b1;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
      end
      S_WR_RSP: begin
        if (m.m_rsp_valid) begin
          if (m.m_rsp_err) begin
            busy_d       = 1'b0;
            err_d        = 1'b1;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end else begin
            src_ptr_d = src_ptr_q + c_step_inc;
            dst_ptr_d = dst_ptr_q + c_step_inc;
            if (end_of_line) begin
              col_d = 32'd0;
              row_d = row_q + 32'd1;
            end else begin
              col_d = col_q + 32'd1;
            end
            if (last_word) begin
              busy_d       = 1'b0;
              done_d       = 1'b1;
              done_pulse_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      line_q       <= '0;
      rows_q       <= '0;
      buf_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      col_q        <= col_d;
      row_q        <= row_d;
      line_q       <= line_d;
      rows_q       <= rows_d;
      buf_q        <= buf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign dma_ctr    = {busy_q, done_q, err_q};
  assign done_pulse = done_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_xfer_ctrl
// Brief    : Directed bench for dma_xfer_ctrl with a zero-wait ICB slave
//            model and an ordered command scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_xfer_ctrl;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_vld = 1'b0;
  logic [31:0] sour_addr = '0;
  logic [31:0] dest_addr = '0;
  logic [31:0] line_size = '0;
  logic [31:0] row_size = '0;
  logic [2:0]  dma_ctr;
  logic        done_pulse;

  logic        cmd_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic        rsp_err = 1'b0;
  logic [31:0] rsp_rdata = '0;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          planned = 0;
  int          cmd_seen = 0;
  int          busy_cycles = 0;
  int          pulses = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          stall_wr = 0;
  int          stall_left = 0;
  int          err_rd = 0;
  bit          rsp_arm = 0;
  bit          fire_pend = 0;
  bit          arm_err = 0;
  logic [31:0] arm_data = '0;

  dma_xfer_ctrl_if #(.AW(32), .DW(32)) m_if ();

  assign m_if.m_cmd_ready = cmd_ready;
  assign m_if.m_rsp_valid = rsp_valid;
  assign m_if.m_rsp_err   = rsp_err;
  assign m_if.m_rsp_rdata = rsp_rdata;

  dma_xfer_ctrl #(.AW(32), .DW(32), .STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_vld    (cfg_vld),
    .sour_addr  (sour_addr),
    .dest_addr  (dest_addr),
    .line_size  (line_size),
    .row_size   (row_size),
    .dma_ctr    (dma_ctr),
    .done_pulse (done_pulse),
    .m          (m_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Slave model: evaluated on the falling edge, so everything seen here is what the next rising edge samples
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_arm   = 1'b0;
      fire_pend = 1'b0;
      cmd_ready = 1'b1;
    end else begin
      if (fire_pend) begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        fire_pend = 1'b0;
      end
      if (rsp_arm) begin
        rsp_valid = 1'b1;
        rsp_err   = arm_err;
        rsp_rdata = arm_data;
        rsp_arm   = 1'b0;
      end
      if (rsp_valid && m_if.m_rsp_ready) fire_pend = 1'b1;
      cmd_ready = 1'b1;
      if (m_if.m_cmd_valid) begin
        if (!m_if.m_cmd_read && (wr_cnt + 1 == stall_wr) && (stall_left > 0)) begin
          cmd_ready = 1'b0;
          stall_left--;
          if (sb.size() > 0) begin
            check("stall_addr",  64'(m_if.m_cmd_addr),  64'(sb[0].addr));
            check("stall_wdata", 64'(m_if.m_cmd_wdata), 64'(sb[0].data));
          end
        end else begin
          cmd_seen++;
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("cmd_read", 64'(m_if.m_cmd_read), 64'(e.rd));
            check("cmd_addr", 64'(m_if.m_cmd_addr), 64'(e.addr));
            if (!e.rd) begin
              check("cmd_wdata", 64'(m_if.m_cmd_wdata), 64'(e.data));
              check("cmd_wmask", 64'(m_if.m_cmd_wmask), 64'h0F);
            end
          end
          if (m_if.m_cmd_read) begin
            rd_cnt++;
            arm_err  = (rd_cnt == err_rd);
            arm_data = mem_val(m_if.m_cmd_addr);
          end else begin
            wr_cnt++;
            arm_err  = 1'b0;
            arm_data = 32'h0;
          end
          rsp_arm = 1'b1;
        end
      end
    end
  end

  // Status monitor
  always @(negedge clk) begin
    if (dma_ctr[2]) busy_cycles++;
    if (done_pulse) pulses++;
  end

  task automatic plan(input logic [31:0] src, input logic [31:0] dst, input int n, input int err_at);
    exp_t e;
    sb.delete();
    planned = 0;
    for (int i = 0; i < n; i++) begin
      e.rd = 1'b1; e.addr = src + 32'(4 * i); e.data = 32'h0;
      sb.push_back(e); planned++;
      if (i == err_at) break;
      e.rd = 1'b0; e.addr = dst + 32'(4 * i); e.data = mem_val(src + 32'(4 * i));
      sb.push_back(e); planned++;
    end
  endtask

  task automatic start(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] ln, input logic [31:0] rw);
    @(negedge clk);
    busy_cycles = 0;
    pulses      = 0;
    cmd_seen    = 0;
    rd_cnt      = 0;
    wr_cnt      = 0;
    sour_addr = src; dest_addr = dst; line_size = ln; row_size = rw;
    cfg_vld = 1'b1;
    @(negedge clk);
    cfg_vld = 1'b0;
    sour_addr = 32'hDEAD_BEE0; dest_addr = 32'hCAFE_0000; line_size = 32'd7; row_size = 32'd9;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done_pulse && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < limit), 64'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic end_checks(input string tag, input logic [2:0] ctr);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_cmd_count"}, 64'(cmd_seen), 64'(planned));
    check({tag, "_dma_ctr"}, 64'(dma_ctr), 64'(ctr));
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_idle"}, 64'(m_if.m_cmd_valid), 64'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_dma_ctr", 64'(dma_ctr), 64'd0);
    check("rst_pulse", 64'(done_pulse), 64'd0);
    check("rst_cmd_valid", 64'(m_if.m_cmd_valid), 64'd0);
    check("rst_rsp_ready", 64'(m_if.m_rsp_ready), 64'd0);
    check("rst_cmd_addr", 64'(m_if.m_cmd_addr), 64'd0);
    check("rst_cmd_wmask", 64'(m_if.m_cmd_wmask), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: plain 3x2 copy
    plan(32'h2000_0000, 32'h2000_1000, 6, -1);
    start(32'h2000_0000, 32'h2000_1000, 32'd3, 32'd2);
    check("t1_busy_rise", 64'(dma_ctr), 64'b100);
    wait_done("t1_done_timeout", 100);
    end_checks("t1", 3'b010);
    check("t1_busy_cycles", 64'(busy_cycles), 64'd24);

    // 2: write backpressure on the second write
    stall_wr = 2; stall_left = 3;
    plan(32'h2000_0000, 32'h2000_1000, 6, -1);
    start(32'h2000_0000, 32'h2000_1000, 32'd3, 32'd2);
    wait_done("t2_done_timeout", 100);
    end_checks("t2", 3'b010);
    check("t2_stalls_used", 64'(stall_left), 64'd0);
    check("t2_busy_cycles", 64'(busy_cycles), 64'd27);
    stall_wr = 0;

    // 3: error on the third read response
    err_rd = 3;
    plan(32'h2000_0000, 32'h2000_1000, 6, 2);
    start(32'h2000_0000, 32'h2000_1000, 32'd3, 32'd2);
    wait_done("t3_done_timeout", 100);
    end_checks("t3", 3'b011);
    err_rd = 0;

    // 4: zero row count completes without traffic
    plan(32'h0, 32'h0, 0, -1);
    start(32'h2000_0000, 32'h2000_1000, 32'd3, 32'd0);
    check("t4_dma_ctr_next", 64'(dma_ctr), 64'b010);
    check("t4_pulse_next", 64'(done_pulse), 64'd1);
    repeat (4) @(negedge clk);
    check("t4_pulses", 64'(pulses), 64'd1);
    check("t4_cmd_count", 64'(cmd_seen), 64'd0);

    // 5: start while busy is ignored, then a fresh start clears status
    plan(32'h2000_0000, 32'h2000_1000, 6, -1);
    start(32'h2000_0000, 32'h2000_1000, 32'd3, 32'd2);
    repeat (6) @(negedge clk);
    sour_addr = 32'h4000_0000; dest_addr = 32'h5000_0000; line_size = 32'd1; row_size = 32'd1;
    cfg_vld = 1'b1;
    @(negedge clk);
    cfg_vld = 1'b0;
    wait_done("t5_done_timeout", 100);
    end_checks("t5", 3'b010);
    check("t5_busy_cycles", 64'(busy_cycles), 64'd24);
    plan(32'h4000_0000, 32'h5000_0000, 1, -1);
    start(32'h4000_0000, 32'h5000_0000, 32'd1, 32'd1);
    check("t5_restart_ctr", 64'(dma_ctr), 64'b100);
    wait_done("t5b_done_timeout", 40);
    end_checks("t5b", 3'b010);

    // 6: asynchronous reset during a write command, then a wrapping copy
    plan(32'h2000_0000, 32'h2000_1000, 6, -1);
    start(32'h2000_0000, 32'h2000_1000, 32'd3, 32'd2);
    begin
      int n = 0;
      while (!(m_if.m_cmd_valid && !m_if.m_cmd_read) && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("t6_wr_cmd_seen", 64'(n < 40), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cmd_valid", 64'(m_if.m_cmd_valid), 64'd0);
    check("t6_rst_dma_ctr", 64'(dma_ctr), 64'd0);
    check("t6_rst_rsp_ready", 64'(m_if.m_rsp_ready), 64'd0);
    check("t6_rst_cmd_addr", 64'(m_if.m_cmd_addr), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    plan(32'hFFFF_FFFC, 32'h3000_0000, 2, -1);
    start(32'hFFFF_FFFC, 32'h3000_0000, 32'd2, 32'd1);
    wait_done("t6_done_timeout", 60);
    end_checks("t6", 3'b010);
    check("t6_busy_cycles", 64'(busy_cycles), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
